// File: rtl/grid_cell_streamer.sv
// Snapshots the 6x5 Wordle board on an accepted frame start and replays it
// cell by cell, row-major, over a valid/ready stream to the tile renderer.
module grid_cell_streamer (
    input  logic         clk,
    input  logic         clr,
    input  logic [209:0] display,
    input  logic         frame_start,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_row,
    output logic [2:0]   out_col,
    output logic [4:0]   out_letter,
    output logic [1:0]   out_color,
    output logic         out_last,
    output logic         out_row_win,
    output logic         busy,
    output logic [7:0]   dropped
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [209:0]   snap_q, snap_d;
    logic [2:0]     row_q, row_d, col_q, col_d;
    logic [7:0]     dropped_q, dropped_d;
    logic [4:0]     letter_q;
    logic [1:0]     color_q;
    logic           last_q, win_q;

    logic           hs, at_end, accept, drop;
    logic [5:0]     row_green;
    logic [7:0]     row_green_x;
    logic [7:0]     base;
    logic [6:0]     cell_d;
    logic           last_d, win_d;

    // Per-row "all five cells green" flags, taken from the snapshot about to
    // be registered so the win flag lines up with the cell being presented.
    for (genvar r = 0; r < 6; r++) begin : g_row
        assign row_green[r] = &{snap_d[35*r+34:35*r+33], snap_d[35*r+27:35*r+26],
                                snap_d[35*r+20:35*r+19], snap_d[35*r+13:35*r+12],
                                snap_d[35*r+6:35*r+5]};
    end
    assign row_green_x = {2'b00, row_green};

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        row_d     = row_q;
        col_d     = col_q;
        dropped_d = dropped_q;

        hs     = (state_q == STREAM) && out_ready;
        at_end = (row_q == 3'd5) && (col_q == 3'd4);
        // In IDLE every request is taken; in STREAM only one that coincides
        // with the final handshake, which restarts with no bubble.
        accept = frame_start && ((state_q == IDLE) || (hs && at_end));
        drop   = frame_start && !accept;

        if (accept) begin
            snap_d  = display;
            row_d   = 3'd0;
            col_d   = 3'd0;
            state_d = STREAM;
        end else if (hs) begin
            if (at_end) begin
                state_d = IDLE;
            end else if (col_q == 3'd4) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end

        if (drop && (dropped_q != 8'hFF))
            dropped_d = dropped_q + 8'd1;

        base   = 8'(row_d) * 8'd35 + 8'(col_d) * 8'd7;
        cell_d = snap_d[base +: 7];
        last_d = (row_d == 3'd5) && (col_d == 3'd4);
        win_d  = (col_d == 3'd4) && row_green_x[row_d];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dropped_q <= '0;
            letter_q  <= '0;
            color_q   <= '0;
            last_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dropped_q <= dropped_d;
            letter_q  <= cell_d[4:0];
            color_q   <= cell_d[6:5];
            last_q    <= last_d;
            win_q     <= win_d;
        end
    end

    assign out_valid   = (state_q == STREAM);
    assign busy        = (state_q == STREAM);
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign out_letter  = letter_q;
    assign out_color   = color_q;
    assign out_last    = last_q;
    assign out_row_win = win_q;
    assign dropped     = dropped_q;

endmodule
